// File: rtl/dmac_if.sv
// Bus-side signal bundle of the single-channel DMA controller: CPU hold handshake,
// peripheral request/acknowledge, register setup port, strobes, address and data.
interface dmac_if;
  logic        HLDA;
  logic        BG;
  logic        DREQ;
  logic        RDY;
  logic        REGW;
  logic [1:0]  REGSEL;
  logic [15:0] Setup;
  logic [7:0]  Data_in;
  logic        HLD;
  logic        DACK;
  logic        MEMR;
  logic        MEMW;
  logic        IOR;
  logic        IOW;
  logic        EOP;
  logic [15:0] Addrbus;
  logic [7:0]  Data_out;

  modport master (
    input  HLDA, BG, DREQ, RDY, REGW, REGSEL, Setup, Data_in,
    output HLD, DACK, MEMR, MEMW, IOR, IOW, EOP, Addrbus, Data_out
  );

  modport slave (
    output HLDA, BG, DREQ, RDY, REGW, REGSEL, Setup, Data_in,
    input  HLD, DACK, MEMR, MEMW, IOR, IOW, EOP, Addrbus, Data_out
  );
endinterface

// File: rtl/dmac.sv
// Single-channel 8-bit DMA controller: requests the bus, moves one byte per READ/WRITE
// pair through a single byte latch, and pulses EOP when the programmed count expires.
module dmac (
  input  logic   CLK,
  input  logic   RST,
  dmac_if.master bus
);

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 8;
  localparam int unsigned CW = 16;

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_READ, S_WRITE, S_UPDATE, S_RELEASE, S_DONE
  } state_e;

  state_e        state_q;
  logic [1:0]    dir_q;
  logic          en_q;
  logic          dec_q;
  logic [1:0]    xfer_q;
  logic [CW-1:0] count_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] latch_q;
  logic          hld_q, dack_q, memr_q, memw_q, ior_q, iow_q, eop_q;
  logic [AW-1:0] addrbus_q;

  logic          grant;
  logic          src_mem, src_io, dst_mem, dst_io;
  logic          steal;
  logic          start;
  logic [AW-1:0] addr_d;
  logic [CW-1:0] count_d;

  // Direction decode: verify mode (11) raises no strobe on either side.
  assign grant   = bus.HLDA | bus.BG;
  assign src_mem = (dir_q == 2'b10) || (dir_q == 2'b01);
  assign src_io  = (dir_q == 2'b00);
  assign dst_mem = (dir_q == 2'b00) || (dir_q == 2'b01);
  assign dst_io  = (dir_q == 2'b10);
  assign steal   = (xfer_q == 2'b10);
  assign start   = en_q & bus.DREQ & ~bus.REGW & (count_q != CW'(0));
  assign addr_d  = dec_q ? addr_q - AW'(1) : addr_q + AW'(1);
  assign count_d = count_q - CW'(1);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= S_IDLE;
      dir_q     <= '0;
      en_q      <= 1'b0;
      dec_q     <= 1'b0;
      xfer_q    <= '0;
      count_q   <= '0;
      addr_q    <= '0;
      latch_q   <= '0;
      hld_q     <= 1'b0;
      dack_q    <= 1'b0;
      memr_q    <= 1'b0;
      memw_q    <= 1'b0;
      ior_q     <= 1'b0;
      iow_q     <= 1'b0;
      eop_q     <= 1'b0;
      addrbus_q <= '0;
    end else begin
      dack_q    <= 1'b0;
      memr_q    <= 1'b0;
      memw_q    <= 1'b0;
      ior_q     <= 1'b0;
      iow_q     <= 1'b0;
      eop_q     <= 1'b0;
      addrbus_q <= '0;
      unique case (state_q)
        S_IDLE: begin
          if (bus.REGW) begin
            unique case (bus.REGSEL)
              2'b00: begin
                dir_q  <= bus.Setup[1:0];
                en_q   <= bus.Setup[4];
                dec_q  <= bus.Setup[5];
                xfer_q <= bus.Setup[7:6];
              end
              2'b01:   count_q <= bus.Setup;
              2'b10:   addr_q  <= bus.Setup;
              default: ;
            endcase
          end else if (start) begin
            state_q <= S_REQ;
            hld_q   <= 1'b1;
          end
        end
        S_REQ: begin
          if (grant) begin
            state_q   <= S_READ;
            dack_q    <= 1'b1;
            addrbus_q <= addr_q;
            memr_q    <= src_mem;
            ior_q     <= src_io;
          end
        end
        // A phase only completes if its strobe was actually on the bus this cycle.
        S_READ: begin
          addrbus_q <= addr_q;
          if (grant) begin
            dack_q <= 1'b1;
            if (dack_q && bus.RDY) begin
              state_q <= S_WRITE;
              latch_q <= bus.Data_in;
              memw_q  <= dst_mem;
              iow_q   <= dst_io;
            end else begin
              memr_q <= src_mem;
              ior_q  <= src_io;
            end
          end
        end
        S_WRITE: begin
          if (grant) begin
            if (dack_q && bus.RDY) begin
              state_q <= S_UPDATE;
            end else begin
              dack_q    <= 1'b1;
              addrbus_q <= addr_q;
              memw_q    <= dst_mem;
              iow_q     <= dst_io;
            end
          end else begin
            addrbus_q <= addr_q;
          end
        end
        S_UPDATE: begin
          addr_q  <= addr_d;
          count_q <= count_d;
          if (count_d == CW'(0)) begin
            state_q <= S_DONE;
            hld_q   <= 1'b0;
            eop_q   <= 1'b1;
            en_q    <= 1'b0;
          end else if (!steal && bus.DREQ) begin
            state_q   <= S_READ;
            dack_q    <= grant;
            addrbus_q <= addr_d;
            memr_q    <= grant & src_mem;
            ior_q     <= grant & src_io;
          end else begin
            state_q <= S_RELEASE;
            hld_q   <= 1'b0;
          end
        end
        S_RELEASE: begin
          if (bus.DREQ) begin
            state_q <= S_REQ;
            hld_q   <= 1'b1;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.HLD      = hld_q;
  assign bus.DACK     = dack_q;
  assign bus.MEMR     = memr_q;
  assign bus.MEMW     = memw_q;
  assign bus.IOR      = ior_q;
  assign bus.IOW      = iow_q;
  assign bus.EOP      = eop_q;
  assign bus.Addrbus  = addrbus_q;
  assign bus.Data_out = latch_q;

endmodule

// File: tb/tb_dmac.sv
// Directed bench for dmac: per-cycle expected strobe/address vectors for each scenario.
module tb_dmac;

  // Control vector order: {HLD, DACK, MEMR, MEMW, IOR, IOW, EOP}
  localparam logic [6:0] C_IDLE   = 7'b0000000;
  localparam logic [6:0] C_HOLD   = 7'b1000000;
  localparam logic [6:0] C_RD_MEM = 7'b1110000;
  localparam logic [6:0] C_WR_IO  = 7'b1100010;
  localparam logic [6:0] C_RD_IO  = 7'b1100100;
  localparam logic [6:0] C_WR_MEM = 7'b1101000;
  localparam logic [6:0] C_EOP    = 7'b0000001;

  logic CLK;
  logic RST;
  int   checks;
  int   errors;

  dmac_if bus ();

  dmac u_dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  logic [6:0] ctl;
  assign ctl = {bus.HLD, bus.DACK, bus.MEMR, bus.MEMW, bus.IOR, bus.IOW, bus.EOP};

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input string tag, input logic [6:0] c, input logic [15:0] a);
    @(posedge CLK);
    #1;
    check({tag, "_ctl"}, 32'(ctl), 32'(c));
    check({tag, "_adr"}, 32'(bus.Addrbus), 32'(a));
  endtask

  task automatic wr_reg(input logic [1:0] sel, input logic [15:0] val);
    bus.REGW   = 1'b1;
    bus.REGSEL = sel;
    bus.Setup  = val;
    @(posedge CLK);
    #1;
  endtask

  task automatic prog(input logic [15:0] mode, input logic [15:0] cnt, input logic [15:0] adr);
    bus.DREQ = 1'b0;
    wr_reg(2'b00, mode);
    wr_reg(2'b01, cnt);
    wr_reg(2'b10, adr);
    bus.REGW = 1'b0;
  endtask

  task automatic run_to_eop(input int budget, output int nbytes, output logic [15:0] last,
                            output logic seen);
    nbytes = 0;
    last   = '0;
    seen   = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(posedge CLK);
      #1;
      if (bus.IOW || bus.MEMW) begin
        nbytes++;
        last = bus.Addrbus;
      end
      if (bus.EOP) seen = 1'b1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int          nb;
    logic [15:0] la;
    logic        seen;
    checks = 0;
    errors = 0;
    RST = 1'b1;
    bus.HLDA = 1'b0; bus.BG = 1'b0; bus.DREQ = 1'b0; bus.RDY = 1'b0;
    bus.REGW = 1'b0; bus.REGSEL = 2'b00; bus.Setup = '0; bus.Data_in = '0;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_ctl", 32'(ctl), 32'(C_IDLE));
    check("rst_adr", 32'(bus.Addrbus), 32'd0);
    check("rst_dout", 32'(bus.Data_out), 32'd0);
    RST = 1'b0;

    // Cycle steal mem->IO, 3 bytes from 0x0001
    prog(16'h0092, 16'd3, 16'h0001);
    bus.DREQ = 1'b1; bus.HLDA = 1'b1; bus.RDY = 1'b1; bus.Data_in = 8'h3C;
    step("t1_req1", C_HOLD,   16'h0000);
    step("t1_rd1",  C_RD_MEM, 16'h0001);
    step("t1_wr1",  C_WR_IO,  16'h0001);
    check("t1_dout", 32'(bus.Data_out), 32'h3C);
    step("t1_upd1", C_HOLD,   16'h0000);
    step("t1_rel1", C_IDLE,   16'h0000);
    step("t1_req2", C_HOLD,   16'h0000);
    step("t1_rd2",  C_RD_MEM, 16'h0002);
    step("t1_wr2",  C_WR_IO,  16'h0002);
    step("t1_upd2", C_HOLD,   16'h0000);
    step("t1_rel2", C_IDLE,   16'h0000);
    step("t1_req3", C_HOLD,   16'h0000);
    step("t1_rd3",  C_RD_MEM, 16'h0003);
    step("t1_wr3",  C_WR_IO,  16'h0003);
    step("t1_upd3", C_HOLD,   16'h0000);
    step("t1_done", C_EOP,    16'h0000);
    step("t1_idle", C_IDLE,   16'h0000);
    step("t1_stay", C_IDLE,   16'h0000);

    // Grant lost for 35 ns during the first READ
    prog(16'h0092, 16'd3, 16'h0001);
    bus.DREQ = 1'b1; bus.Data_in = 8'h4B;
    step("t2_req",  C_HOLD,   16'h0000);
    step("t2_rd",   C_RD_MEM, 16'h0001);
    bus.HLDA = 1'b0;
    fork
      begin
        #35;
        bus.HLDA = 1'b1;
      end
    join_none
    step("t2_lost0", C_HOLD,   16'h0001);
    step("t2_lost1", C_HOLD,   16'h0001);
    step("t2_lost2", C_HOLD,   16'h0001);
    step("t2_back",  C_RD_MEM, 16'h0001);
    step("t2_wr",    C_WR_IO,  16'h0001);
    step("t2_upd",   C_HOLD,   16'h0000);
    step("t2_rel",   C_IDLE,   16'h0000);
    run_to_eop(40, nb, la, seen);
    check("t2_eop", 32'(seen), 32'd1);
    check("t2_bytes", 32'(nb), 32'd2);
    check("t2_last", 32'(la), 32'h0003);
    step("t2_idle", C_IDLE, 16'h0000);

    // RDY low for 4 cycles during READ
    prog(16'h0092, 16'd1, 16'h0010);
    bus.DREQ = 1'b1; bus.Data_in = 8'h11;
    step("t3_req", C_HOLD,   16'h0000);
    step("t3_rd",  C_RD_MEM, 16'h0010);
    bus.RDY = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step("t3_wait", C_RD_MEM, 16'h0010);
      check("t3_wait_dout", 32'(bus.Data_out), 32'h4B);
    end
    bus.RDY = 1'b1; bus.Data_in = 8'h77;
    step("t3_wr", C_WR_IO, 16'h0010);
    check("t3_dout", 32'(bus.Data_out), 32'h77);
    bus.Data_in = 8'h00;
    step("t3_upd",  C_HOLD, 16'h0000);
    step("t3_done", C_EOP,  16'h0000);
    step("t3_idle", C_IDLE, 16'h0000);
    check("t3_dout_hold", 32'(bus.Data_out), 32'h77);

    // Block IO->mem, 2 bytes, address wraps 0xFFFF -> 0x0000
    prog(16'h0050, 16'd2, 16'hFFFF);
    bus.DREQ = 1'b1; bus.Data_in = 8'hC3;
    step("t4_req",  C_HOLD,   16'h0000);
    step("t4_rd1",  C_RD_IO,  16'hFFFF);
    step("t4_wr1",  C_WR_MEM, 16'hFFFF);
    check("t4_dout", 32'(bus.Data_out), 32'hC3);
    step("t4_upd1", C_HOLD,   16'h0000);
    step("t4_rd2",  C_RD_IO,  16'h0000);
    step("t4_wr2",  C_WR_MEM, 16'h0000);
    step("t4_upd2", C_HOLD,   16'h0000);
    step("t4_done", C_EOP,    16'h0000);
    step("t4_idle", C_IDLE,   16'h0000);

    // Zero count never starts
    prog(16'h0092, 16'd0, 16'h0005);
    bus.DREQ = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step("t5_zero", C_IDLE, 16'h0000);
    end

    // Reset asserted mid-WRITE
    prog(16'h0092, 16'd2, 16'h0020);
    bus.DREQ = 1'b1; bus.Data_in = 8'h99;
    step("t6_req", C_HOLD,   16'h0000);
    step("t6_rd",  C_RD_MEM, 16'h0020);
    step("t6_wr",  C_WR_IO,  16'h0020);
    #3;
    RST = 1'b1;
    #1;
    check("t6_async_ctl", 32'(ctl), 32'(C_IDLE));
    check("t6_async_adr", 32'(bus.Addrbus), 32'd0);
    check("t6_async_dout", 32'(bus.Data_out), 32'd0);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step("t6_after", C_IDLE, 16'h0000);
    end
    wr_reg(2'b00, 16'h0092);
    bus.REGW = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step("t6_cnt_clr", C_IDLE, 16'h0000);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
